rfft_io_ram: RTL and testbench

RFFT_IO_RAM -- requirements
Module: rfft_io_ram

---
 rtl/rfft_io_ram_if.sv | 44 ++++
 rtl/rfft_io_ram.sv | 158 +++++++++++++++
 tb/tb_rfft_io_ram.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfft_io_ram_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : rfft_io_ram_if                                               |
// | Description : Host and FFT-core signal bundle for the rfft_io_ram sample   |
// |               buffer. The slave modport is the buffer; the master modport  |
// |               is whoever drives the host strobes and the core port.        |
// | Signals     : Input/Write/Addr/Din0..3   host load/unload request          |
// |               Dout0..3/done/load_err     host results and status           |
// |               start                      one-cycle kick to the FFT core    |
// |               core_addr/we/wdata/done    FFT core access port              |
// |               core_rdata                 registered core read data         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rfft_io_ram_if #(
   parameter int WIDTH = 16
);
   logic             Input;
   logic             Write;
   logic [5:0]       Addr;
   logic [WIDTH-1:0] Din0, Din1, Din2, Din3;
   logic [WIDTH-1:0] Dout0, Dout1, Dout2, Dout3;
   logic             done;
   logic             load_err;
   logic             start;
   logic [7:0]       core_addr;
   logic             core_we;
   logic [WIDTH-1:0] core_wdata;
   logic [WIDTH-1:0] core_rdata;
   logic             core_done;

   modport slave (
      input  Input, Write, Addr, Din0, Din1, Din2, Din3,
      input  core_addr, core_we, core_wdata, core_done,
      output Dout0, Dout1, Dout2, Dout3, done, load_err, start, core_rdata
   );

   modport master (
      output Input, Write, Addr, Din0, Din1, Din2, Din3,
      output core_addr, core_we, core_wdata, core_done,
      input  Dout0, Dout1, Dout2, Dout3, done, load_err, start, core_rdata
   );
endinterface
`default_nettype wire

// File: rtl/rfft_io_ram.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : rfft_io_ram                                                  |
// | Description : 256-sample I/O buffer for a real FFT core. The host loads    |
// |               64 quad-words, the core is started and works in place, then  |
// |               the host unloads 64 quad-words. Storage is four 64xWIDTH     |
// |               banks: bank = sample[1:0], row = sample[7:2].                |
// | Ports       : Clk      rising-edge clock                                   |
// |               Reset_n  asynchronous active-low reset (memory not cleared)  |
// |               bus      rfft_io_ram_if.slave, host and core signals         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rfft_io_ram #(
   parameter int WIDTH = 16
) (
   input wire           Clk,
   input wire           Reset_n,
   rfft_io_ram_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_CORE  = 2'd2;
   localparam logic [1:0] S_READY = 2'd3;

   localparam logic [6:0] C_LAST = 7'd63;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [6:0]       r_load_cnt;
   logic [6:0]       r_rd_cnt;
   logic             r_done;
   logic             r_load_err;
   logic             r_start;
   logic [WIDTH-1:0] r_dout [4];
   logic [WIDTH-1:0] r_core_rdata;

   logic             w_host_we;
   logic             w_load_first;
   logic             w_load_last;
   logic             w_load_short;
   logic             w_core_we;
   logic             w_core_fin;
   logic             w_rd_en;
   logic             w_last_rd;

   logic [WIDTH-1:0] w_din     [4];
   logic [WIDTH-1:0] w_host_rd [4];
   logic [WIDTH-1:0] w_core_rd [4];

   assign w_din[0] = bus.Din0;
   assign w_din[1] = bus.Din1;
   assign w_din[2] = bus.Din2;
   assign w_din[3] = bus.Din3;

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.Input) w_next = S_LOAD;
         S_LOAD: begin
            if (!bus.Input)               w_next = S_IDLE;
            else if (r_load_cnt == C_LAST) w_next = S_CORE;
         end
         S_CORE:  if (bus.core_done) w_next = S_READY;
         S_READY: begin
            // A new load always wins over an unload in progress
            if (bus.Input)                             w_next = S_LOAD;
            else if (bus.Write && r_rd_cnt == C_LAST)  w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Control strobes decoded from state and inputs
   always_comb begin
      w_host_we    = bus.Input && (r_state != S_CORE);
      w_load_first = bus.Input && ((r_state == S_IDLE) || (r_state == S_READY));
      w_load_last  = bus.Input && (r_state == S_LOAD) && (r_load_cnt == C_LAST);
      w_load_short = !bus.Input && (r_state == S_LOAD);
      w_core_we    = bus.core_we && (r_state == S_CORE);
      w_core_fin   = bus.core_done && (r_state == S_CORE);
      w_rd_en      = bus.Write && !bus.Input && (r_state == S_READY);
      w_last_rd    = w_rd_en && (r_rd_cnt == C_LAST);
   end

   // Sample banks: host writes a full row across all banks, the core writes
   // one sample. The two writers are exclusive by state.
   for (genvar b = 0; b < 4; b++) begin : g_bank
      logic [WIDTH-1:0] r_ram [64];

      always_ff @(posedge Clk) begin
         if (w_host_we) begin
            r_ram[bus.Addr] <= w_din[b];
         end else if (w_core_we && (bus.core_addr[1:0] == 2'(b))) begin
            r_ram[bus.core_addr[7:2]] <= bus.core_wdata;
         end
      end

      assign w_host_rd[b] = r_ram[bus.Addr];
      assign w_core_rd[b] = r_ram[bus.core_addr[7:2]];
   end

   // Counters, status flags and registered read ports
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_load_cnt   <= '0;
         r_rd_cnt     <= '0;
         r_done       <= 1'b0;
         r_load_err   <= 1'b0;
         r_start      <= 1'b0;
         r_core_rdata <= '0;
         for (int k = 0; k < 4; k++) r_dout[k] <= '0;
      end else begin
         r_start <= w_load_last;

         if (w_load_first)   r_load_cnt <= 7'd1;
         else if (w_host_we) r_load_cnt <= r_load_cnt + 7'd1;

         if (w_load_first)      r_load_err <= 1'b0;
         else if (w_load_short) r_load_err <= 1'b1;

         if (w_core_fin)                     r_done <= 1'b1;
         else if (w_load_first || w_last_rd) r_done <= 1'b0;

         if (w_core_fin)   r_rd_cnt <= '0;
         else if (w_rd_en) r_rd_cnt <= r_rd_cnt + 7'd1;

         if (w_rd_en) begin
            for (int k = 0; k < 4; k++) r_dout[k] <= w_host_rd[k];
         end

         // Reads the pre-write contents, so a same-cycle core write returns old data
         r_core_rdata <= w_core_rd[bus.core_addr[1:0]];
      end
   end

   assign bus.Dout0      = r_dout[0];
   assign bus.Dout1      = r_dout[1];
   assign bus.Dout2      = r_dout[2];
   assign bus.Dout3      = r_dout[3];
   assign bus.done       = r_done;
   assign bus.load_err   = r_load_err;
   assign bus.start      = r_start;
   assign bus.core_rdata = r_core_rdata;

endmodule
`default_nettype wire

// File: tb/tb_rfft_io_ram.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_rfft_io_ram                                               |
// | Description : Directed testbench for rfft_io_ram. Stimulus pushes expected |
// |               register values tagged with the cycle they must appear in;   |
// |               a negedge monitor pops and compares them.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rfft_io_ram;

   localparam int K_START = 0;
   localparam int K_DONE  = 1;
   localparam int K_LERR  = 2;
   localparam int K_RDATA = 3;
   localparam int K_DOUT0 = 4;

   typedef struct {
      int          due;
      int          kind;
      logic [15:0] req;
   } exp_t;

   logic Clk;
   logic Reset_n;
   int   cyc;
   int   total;
   int   bad;
   exp_t sbq[$];
   exp_t m_e;

   rfft_io_ram_if #(.WIDTH(16)) bus ();

   rfft_io_ram #(.WIDTH(16)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [15:0] act, logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   function automatic string kname(int kind);
      case (kind)
         K_START: return "start";
         K_DONE:  return "done";
         K_LERR:  return "load_err";
         K_RDATA: return "core_rdata";
         K_DOUT0: return "Dout0";
         5:       return "Dout1";
         6:       return "Dout2";
         default: return "Dout3";
      endcase
   endfunction

   function automatic logic [15:0] act_of(int kind);
      case (kind)
         K_START: return {15'd0, bus.start};
         K_DONE:  return {15'd0, bus.done};
         K_LERR:  return {15'd0, bus.load_err};
         K_RDATA: return bus.core_rdata;
         K_DOUT0: return bus.Dout0;
         5:       return bus.Dout1;
         6:       return bus.Dout2;
         default: return bus.Dout3;
      endcase
   endfunction

   // Expected value must be visible after the next rising edge
   function automatic void push(int kind, logic [15:0] req);
      sbq.push_back('{due: cyc + 1, kind: kind, req: req});
   endfunction

   // Monitor: compare every expectation that has come due
   always @(negedge Clk) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         m_e = sbq.pop_front();
         chk(kname(m_e.kind), act_of(m_e.kind), m_e.req);
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_start"},  {15'd0, bus.start},    16'd0);
      chk({tag, "_done"},   {15'd0, bus.done},     16'd0);
      chk({tag, "_lerr"},   {15'd0, bus.load_err}, 16'd0);
      chk({tag, "_rdata"},  bus.core_rdata,        16'd0);
      chk({tag, "_dout0"},  bus.Dout0,             16'd0);
      chk({tag, "_dout1"},  bus.Dout1,             16'd0);
      chk({tag, "_dout2"},  bus.Dout2,             16'd0);
      chk({tag, "_dout3"},  bus.Dout3,             16'd0);
   endtask

   task automatic set_din(input logic [15:0] v0);
      bus.Din0 = v0;
      bus.Din1 = v0 + 16'd1;
      bus.Din2 = v0 + 16'd2;
      bus.Din3 = v0 + 16'd3;
   endtask

   // 64-word load with sample value base + index, then one idle cycle
   task automatic load_full(input logic [15:0] base);
      for (int i = 0; i < 64; i++) begin
         bus.Input = 1'b1;
         bus.Addr  = 6'(i);
         set_din(base + 16'(4 * i));
         push(K_START, (i == 63) ? 16'd1 : 16'd0);
         push(K_LERR, 16'd0);
         push(K_DONE, 16'd0);
         step();
      end
      bus.Input = 1'b0;
      push(K_START, 16'd0);
      step();
   endtask

   task automatic core_done_pulse(input logic [15:0] exp_done);
      bus.core_done = 1'b1;
      push(K_DONE, exp_done);
      push(K_START, 16'd0);
      step();
      bus.core_done = 1'b0;
      push(K_DONE, exp_done);
      push(K_START, 16'd0);
      step();
   endtask

   task automatic pulse_reset(string tag);
      @(negedge Clk);
      #1;
      Reset_n = 1'b0;
      #1;
      check_all_zero(tag);
      step();
      Reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      bus.Input = 1'b0; bus.Write = 1'b0; bus.Addr = '0;
      set_din(16'd0);
      bus.core_addr = '0; bus.core_we = 1'b0; bus.core_wdata = '0; bus.core_done = 1'b0;
      Reset_n = 1'b0;
      #12;
      check_all_zero("reset");
      step();
      Reset_n = 1'b1;
      step();

      // Full load, sample value = index
      load_full(16'd0);

      // Write in CORE is ignored
      bus.Write = 1'b1; bus.Addr = 6'd5;
      push(K_DOUT0, 16'd0);
      step();
      bus.Write = 1'b0;

      // Core reads, then writes 255-addr (same-cycle read returns old value)
      for (int a = 0; a < 256; a++) begin
         bus.core_addr = 8'(a);
         push(K_RDATA, 16'(a));
         step();
      end
      for (int a = 0; a < 256; a++) begin
         bus.core_addr  = 8'(a);
         bus.core_we    = 1'b1;
         bus.core_wdata = 16'(255 - a);
         push(K_RDATA, 16'(a));
         step();
      end
      bus.core_we = 1'b0;
      bus.core_addr = 8'd7;
      push(K_RDATA, 16'd248);
      step();
      core_done_pulse(16'd1);

      // Unload
      for (int a = 0; a < 64; a++) begin
         bus.Write = 1'b1;
         bus.Addr  = 6'(a);
         for (int k = 0; k < 4; k++) push(K_DOUT0 + k, 16'(255 - (4 * a + k)));
         push(K_DONE, (a == 63) ? 16'd0 : 16'd1);
         step();
      end
      bus.Write = 1'b0;
      push(K_DOUT0, 16'd3);
      push(K_DOUT0 + 3, 16'd0);
      push(K_DONE, 16'd0);
      step();
      // Now IDLE: Write and core_done ignored
      bus.Write = 1'b1; bus.Addr = 6'd20;
      push(K_DOUT0, 16'd3);
      step();
      bus.Write = 1'b0;
      core_done_pulse(16'd0);

      // Short load of 10 words
      for (int i = 0; i < 10; i++) begin
         bus.Input = 1'b1;
         bus.Addr  = 6'(i);
         set_din(16'h0AA0);
         push(K_START, 16'd0);
         push(K_LERR, 16'd0);
         step();
      end
      bus.Input = 1'b0;
      push(K_LERR, 16'd1);
      push(K_START, 16'd0);
      step();
      push(K_LERR, 16'd1);
      push(K_START, 16'd0);
      step();
      load_full(16'd0);
      core_done_pulse(16'd1);

      // From READY: Input+Write together aborts unload; Input held 70 cycles
      for (int i = 0; i < 70; i++) begin
         bus.Input = 1'b1;
         bus.Write = (i == 0);
         bus.Addr  = 6'(i % 64);
         set_din((i < 64) ? 16'(16'h0100 + 4 * i) : 16'(16'hF000 + 16 * i));
         if (i == 0) push(K_DOUT0, 16'd3);
         push(K_START, (i == 63) ? 16'd1 : 16'd0);
         push(K_DONE, 16'd0);
         step();
      end
      bus.Input = 1'b0;
      bus.Write = 1'b0;
      push(K_START, 16'd0);
      step();
      for (int a = 0; a < 256; a++) begin
         bus.core_addr = 8'(a);
         push(K_RDATA, 16'(16'h0100 + a));
         step();
      end

      // Reset in CORE
      pulse_reset("rst_core");
      core_done_pulse(16'd0);
      // Memory survives reset; core_we ignored outside CORE; rdata still tracks
      bus.core_addr = 8'd9; bus.core_we = 1'b1; bus.core_wdata = 16'hDEAD;
      push(K_RDATA, 16'h0109);
      step();
      bus.core_we = 1'b0;
      push(K_RDATA, 16'h0109);
      step();

      // Reset in READY
      load_full(16'd0);
      core_done_pulse(16'd1);
      bus.Write = 1'b1; bus.Addr = 6'd10;
      for (int k = 0; k < 4; k++) push(K_DOUT0 + k, 16'(40 + k));
      push(K_DONE, 16'd1);
      step();
      bus.Write = 1'b0;
      pulse_reset("rst_ready");
      core_done_pulse(16'd0);
      bus.Write = 1'b1; bus.Addr = 6'd10;
      push(K_DOUT0, 16'd0);
      push(K_DONE, 16'd0);
      step();
      bus.Write = 1'b0;

      @(negedge Clk);
      #1;
      chk("scoreboard_drain", 16'(sbq.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
